// File: rtl/spi_master.sv
// SPI mode-0 master: shifts a {rw, addr, data} frame MSB first and captures the data field from miso.
// Optional SPI_MASTER_LOOPBACK_EN adds a loopback input that samples mosi in place of miso.
module spi_master #(
  parameter int msg_width  = 32,
  parameter int addr_width = 7,
  parameter int clk_div    = 4,
  localparam int data_width = msg_width - addr_width - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  rw,
  input  logic [addr_width-1:0] addr,
  input  logic [data_width-1:0] wdata,
  output logic [data_width-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  sck,
  output logic                  ncs,
  output logic                  mosi,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic                  loopback,
`endif
  input  logic                  miso
);

  localparam int BW = $clog2(msg_width) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SCK_HI,
    S_SCK_LO,
    S_GAP
  } state_t;

  state_t                r_state;
  logic [7:0]            r_hcnt;
  logic [BW-1:0]         r_bcnt;
  logic [msg_width-2:0]  r_shift;
  logic [data_width-1:0] r_rdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_sck;
  logic                  r_ncs;
  logic                  r_mosi;

  logic w_hend;
  logic w_last;
  logic w_cap;
  logic w_sample;

  assign w_hend = (r_hcnt == 8'(clk_div - 1));
  assign w_last = (r_bcnt == BW'(msg_width));
  // r_bcnt holds the index of the bit whose rising edge is next
  assign w_cap  = (r_bcnt >= BW'(addr_width + 1));

`ifdef SPI_MASTER_LOOPBACK_EN
  assign w_sample = loopback ? r_mosi : miso;
`else
  assign w_sample = miso;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_hcnt  <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sck   <= 1'b0;
      r_ncs   <= 1'b1;
      r_mosi  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_sck <= 1'b0;
          r_ncs <= 1'b1;
          if (start) begin
            r_state <= S_SETUP;
            r_busy  <= 1'b1;
            r_ncs   <= 1'b0;
            r_mosi  <= rw;
            r_shift <= {addr, wdata};
            r_hcnt  <= '0;
            r_bcnt  <= '0;
          end
        end
        S_SETUP: begin
          if (w_hend) begin
            r_state <= S_SCK_HI;
            r_sck   <= 1'b1;
            r_hcnt  <= '0;
            if (w_cap)
              r_rdata <= {r_rdata[data_width-2:0], w_sample};
          end else begin
            r_hcnt <= r_hcnt + 8'd1;
          end
        end
        S_SCK_HI: begin
          if (w_hend) begin
            r_state <= S_SCK_LO;
            r_sck   <= 1'b0;
            r_hcnt  <= '0;
            r_bcnt  <= r_bcnt + BW'(1);
            r_mosi  <= r_shift[msg_width-2];
            r_shift <= {r_shift[msg_width-3:0], 1'b0};
          end else begin
            r_hcnt <= r_hcnt + 8'd1;
          end
        end
        S_SCK_LO: begin
          if (w_hend) begin
            r_hcnt <= '0;
            if (w_last) begin
              r_state <= S_GAP;
              r_ncs   <= 1'b1;
              r_done  <= 1'b1;
              r_mosi  <= 1'b0;
            end else begin
              r_state <= S_SCK_HI;
              r_sck   <= 1'b1;
              if (w_cap)
                r_rdata <= {r_rdata[data_width-2:0], w_sample};
            end
          end else begin
            r_hcnt <= r_hcnt + 8'd1;
          end
        end
        S_GAP: begin
          if (w_hend) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_hcnt  <= '0;
            r_bcnt  <= '0;
          end else begin
            r_hcnt <= r_hcnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ncs   <= 1'b1;
          r_sck   <= 1'b0;
        end
      endcase
    end
  end

  assign rdata = r_rdata;
  assign busy  = r_busy;
  assign done  = r_done;
  assign sck   = r_sck;
  assign ncs   = r_ncs;
  assign mosi  = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Randomized bench for spi_master against a frame-level reference model.
// Define SPI_MASTER_LOOPBACK_EN to also exercise the loopback input.
module tb_spi_master;
  localparam int MW = 32;
  localparam int AW = 7;
  localparam int DW = 24;
  localparam int CD = 4;
  localparam int NCS_LOW = (2 * MW + 1) * CD;
  localparam int BUSY_HI = NCS_LOW + CD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic rw = 1'b0;
  logic miso = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic busy, done, sck, ncs, mosi;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic loopback = 1'b0;
`endif

  logic start2 = 1'b0;
  logic miso2 = 1'b0;
  logic [DW-1:0] rdata2;
  logic busy2, done2, sck2, ncs2, mosi2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] resp = '0;
  int ncs_cnt = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int rise_cnt = 0;
  int rises = 0;
  int rise2_cnt = 0;
  int done2_cnt = 0;
  logic psck = 1'b0;
  logic psck2 = 1'b0;
  logic [31:0] mosi_q = '0;

  spi_master #(.msg_width(MW), .addr_width(AW), .clk_div(CD)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .busy(busy), .done(done), .sck(sck), .ncs(ncs), .mosi(mosi),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(loopback),
`endif
    .miso(miso)
  );

  spi_master #(.msg_width(MW), .addr_width(AW), .clk_div(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .rw(rw),
    .addr(addr), .wdata(wdata), .rdata(rdata2),
    .busy(busy2), .done(done2), .sck(sck2), .ncs(ncs2), .mosi(mosi2),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .miso(miso2)
  );

  always #5 clk = ~clk;

  // bus monitor: tallies per-cycle activity and collects mosi at sck rises
  always @(negedge clk) begin
    psck  <= sck;
    psck2 <= sck2;
    if (!ncs) ncs_cnt <= ncs_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (done2) done2_cnt <= done2_cnt + 1;
    if (ncs) rises <= 0;
    else if (sck && !psck) rises <= rises + 1;
    if (sck && !psck) begin
      rise_cnt <= rise_cnt + 1;
      mosi_q   <= {mosi_q[30:0], mosi};
    end
    if (sck2 && !psck2) rise2_cnt <= rise2_cnt + 1;
  end

  // slave: presents resp MSB first, changing only while sck is low
  always @(negedge clk) begin
    if (ncs) miso <= 1'b0;
    else if (!sck && rises < MW) miso <= resp[MW-1-rises];
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic irw, input logic [AW-1:0] ia,
                      input logic [DW-1:0] iw, input logic [31:0] ir,
                      input bit lb, input bit poke);
    int c0, b0, d0, r0;
    bit got;
    logic [DW-1:0] er;
    logic [31:0] ef;
    ef = {irw, ia, iw};
    er = lb ? iw : ir[DW-1:0];
    resp = ir;
    @(posedge clk); #1;
    c0 = ncs_cnt; b0 = busy_cnt; d0 = done_cnt; r0 = rise_cnt;
    rw = irw; addr = ia; wdata = iw; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wdata = DW'($urandom);
    addr  = AW'($urandom);
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (poke && i == 100) start = 1'b1;
      if (poke && i == 101) start = 1'b0;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", 64'(got), 64'(1));
    check("rdata_at_done", 64'(rdata), 64'(er));
    if (poke) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        got = 1'b1;
        break;
      end
    end
    check("idle_seen", 64'(got), 64'(1));
    @(posedge clk); #1;
    check("mosi_frame", 64'(mosi_q), 64'(ef));
    check("sck_rises", 64'(rise_cnt - r0), 64'(MW));
    check("ncs_low", 64'(ncs_cnt - c0), 64'(NCS_LOW));
    check("busy_high", 64'(busy_cnt - b0), 64'(BUSY_HI));
    check("done_pulses", 64'(done_cnt - d0), 64'(1));
    repeat (20) @(posedge clk);
    #1;
    check("rdata_hold", 64'(rdata), 64'(er));
    if (poke) check("no_extra_frame", 64'(ncs_cnt - c0), 64'(NCS_LOW));
  endtask

  initial begin
    int d0, r0, n;
    bit got;
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, r0, n;
    bit got;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ncs", 64'(ncs), 64'(1));
    check("rst_sck", 64'(sck), 64'(0));
    check("rst_mosi", 64'(mosi), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    rst_n = 1'b1;

    xfer(1'b0, 7'h15, 24'hA5C33C, 32'h0, 1'b0, 1'b0);
    xfer(1'b1, 7'h02, 24'h000000, 32'hFF123456, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++)
      xfer(1'($urandom), AW'($urandom), DW'($urandom), $urandom, 1'b0, 1'b0);
    xfer(1'($urandom), AW'($urandom), DW'($urandom), $urandom, 1'b0, 1'b1);

    // reset in the middle of a frame
    resp = 32'hFFFFFFFF;
    @(posedge clk); #1;
    rw = 1'b1; addr = 7'h33; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d0 = done_cnt;
    got = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (rises == 10) begin
        got = 1'b1;
        break;
      end
    end
    check("reach_edge10", 64'(got), 64'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_ncs", 64'(ncs), 64'(1));
    check("midrst_sck", 64'(sck), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_rdata", 64'(rdata), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_done", 64'(done_cnt - d0), 64'(0));
    xfer(1'b0, AW'($urandom), DW'($urandom), $urandom, 1'b0, 1'b0);

`ifdef SPI_MASTER_LOOPBACK_EN
    loopback = 1'b1;
    xfer(1'b0, 7'h55, 24'hFFFFFF, 32'h0, 1'b1, 1'b0);
    loopback = 1'b0;
`endif

    // back-to-back frames on the clk_div=1 instance
    r0 = rise2_cnt;
    d0 = done2_cnt;
    @(posedge clk); #1;
    start2 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!ncs2) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("b2b_first_low", 64'(got), 64'(1));
    n = 0;
    while (!ncs2 && n < 1000) begin
      n++;
      @(posedge clk); #1;
    end
    check("b2b_low1", 64'(n), 64'(2 * MW + 1));
    n = 0;
    while (ncs2 && n < 1000) begin
      n++;
      @(posedge clk); #1;
    end
    check("b2b_gap", 64'(n), 64'(2));
    n = 0;
    while (!ncs2 && n < 1000) begin
      n++;
      @(posedge clk); #1;
    end
    start2 = 1'b0;
    check("b2b_low2", 64'(n), 64'(2 * MW + 1));
    repeat (10) @(posedge clk);
    #1;
    check("b2b_rises", 64'(rise2_cnt - r0), 64'(2 * MW));
    check("b2b_dones", 64'(done2_cnt - d0), 64'(2));
    check("b2b_idle", 64'({busy2, ncs2}), 64'(2'b01));
    check("b2b_rdata", 64'(rdata2), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter msg_width, default 32, total frame bits: [R/W bit, addr, data], MSB first.
REQ-002 SHALL have parameter addr_width, default 7, address field width; data_width = msg_width - addr_width - 1 (24 by default).
REQ-003 SHALL have parameter clk_div, default 4, SCK half-period in clk cycles; legal range 1 to 255.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  transaction request; sampled in IDLE only.
REQ-007 SHALL have port rw  input  1  frame bit 0; 1 = read, 0 = write.
REQ-008 SHALL have port addr  input  addr_width  target register address.
REQ-009 SHALL have port wdata  input  data_width  write payload, don't-care for reads.
REQ-010 SHALL have port rdata  output  data_width  data captured from miso during the data field.
REQ-011 SHALL have port busy  output  1  high from the cycle after start is accepted until return to IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse at transaction end; rdata is valid from this cycle.
REQ-013 SHALL have ports sck (output, 1), ncs (output, 1, active-low), mosi (output, 1) and miso (input, 1): SPI mode 0 bus to the MCU-side slave.

Function
REQ-014 SHALL implement states IDLE, SETUP, SCK_HI, SCK_LO and GAP, using a half-period counter plus a bit counter sized clog2(msg_width)+1.
REQ-015 IDLE: ncs=1, sck=0; start=1 latches {rw, addr, wdata} into the shift register, drives ncs=0 and mosi=frame MSB on the next edge, and enters SETUP.
REQ-016 SETUP SHALL last clk_div cycles with sck=0, then enter SCK_HI.
REQ-017 On entry to SCK_HI, sck SHALL rise and miso SHALL be sampled on that same clk edge using the pre-edge value; SCK_HI SHALL last clk_div cycles.
REQ-018 On entry to SCK_LO, sck SHALL fall and mosi SHALL advance to the next frame bit; SCK_LO SHALL last clk_div cycles.
REQ-019 Samples for bit indices addr_width+1 to msg_width-1 SHALL shift into rdata MSB first; samples from the R/W and address bits SHALL be discarded.
REQ-020 After the SCK_LO of bit msg_width-1, the block SHALL set ncs=1, pulse done for one cycle, clear mosi and enter GAP.
REQ-021 GAP SHALL last clk_div cycles with ncs=1, then enter IDLE with busy=0.
REQ-022 ncs low time SHALL be exactly (2*msg_width+1)*clk_div clk cycles.
REQ-023 start while busy=1 (including during GAP) SHALL be ignored and not queued.
REQ-024 rdata SHALL hold its value between transactions and update only at the bit-sample edges of a new transaction.
REQ-025 Reads and writes SHALL use identical timing; rdata is captured for writes as well.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, ncs=1, sck=0, mosi=0, busy=0, done=0, rdata=0 and clear both counters.
REQ-027 Reset mid-transaction SHALL deassert ncs immediately without a done pulse; the first start after rst_n rises SHALL begin a clean frame.

Configuration
REQ-028 With macro SPI_MASTER_LOOPBACK_EN defined, the block SHALL add input loopback; when loopback=1, the sampled data SHALL be the mosi value in place of miso, and sck, ncs and mosi still toggle.
REQ-029 Without SPI_MASTER_LOOPBACK_EN, the loopback port and mux SHALL be absent and miso SHALL always be sampled.

Verification
REQ-030 Write, clk_div=4: start with rw=0, addr=0x15, wdata=0xA5C33C -> mosi at the 32 sck rising edges = 0x15A5C33C (bit 31 first), ncs low 260 cycles, busy high 264 cycles, one done pulse.
REQ-031 Read: rw=1, addr=0x02, slave model returns 0x123456 in the data field -> mosi frame bits 31..24 = 0x82, and rdata=0x123456 at done.
REQ-032 clk_div=1: back-to-back start held high -> second frame begins exactly 1 cycle after GAP ends, and no frame overlap is seen on ncs.
REQ-033 rst_n pulsed low at sck edge 10 -> ncs=1, sck=0 in the same cycle, no done, and the next start produces a full 32-edge frame.
REQ-034 SPI_MASTER_LOOPBACK_EN defined, loopback=1, miso tied to 0, wdata=0xFFFFFF -> rdata=0xFFFFFF.
REQ-035 start pulsed while busy (mid-frame and in GAP) -> frame unaffected and no extra transaction.
